// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - write-port and UART-driver link interfaces for uart_tx_feeder

interface uart_tx_feeder_wr_if #(
    parameter int WIDTH = 9
);
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

interface uart_tx_feeder_drv_if #(
    parameter int WIDTH = 9
);
    logic             uart_start;
    logic [WIDTH-1:0] uart_data;
    logic             uart_ready;
    logic             uart_busy;

    modport master (output uart_start, output uart_data, input  uart_ready, input  uart_busy);
    modport slave  (input  uart_start, input  uart_data, output uart_ready, output uart_busy);
endinterface

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO-buffered frame launcher in front of the UART transmit driver

module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int WIDTH        = 9,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_feeder_wr_if.slave       wr,
    input  logic                     flush,
    uart_tx_feeder_drv_if.master     drv,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic                     tx_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             launch_ok;

    state_t           state_q;
    state_t           state_d;
    logic [TW-1:0]    timer_q;
    logic             start_d;
    logic             timeout_hit;
    logic             uart_start_q;
    logic [WIDTH-1:0] uart_data_q;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign wr.wr_ready = !fifo_full;

    // flush wins over both queue operations, so it also blocks a launch this cycle
    assign push      = wr.wr_valid && !fifo_full && !flush;
    assign launch_ok = !fifo_empty && drv.uart_ready && !drv.uart_busy && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (wr.wr_valid && fifo_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (launch_ok) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (drv.uart_busy)              state_d = WAIT_DONE;
                else if (timer_q == TIMER_LAST) state_d = IDLE;
            end
            WAIT_DONE: if (!drv.uart_busy && drv.uart_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        start_d     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE:     pop         = launch_ok;
            LAUNCH:   start_d     = 1'b1;
            WAIT_ACK: timeout_hit = !drv.uart_busy && (timer_q == TIMER_LAST);
            default:  ;
        endcase
    end

    // start is registered so its pulse lines up with the first WAIT_ACK cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uart_start_q <= 1'b0;
            uart_data_q  <= '0;
            timer_q      <= '0;
            tx_timeout   <= 1'b0;
        end else begin
            uart_start_q <= start_d;
            if (pop) uart_data_q <= mem[rd_ptr];
            if (state_q == LAUNCH) begin
                timer_q <= '0;
            end else if (state_q == WAIT_ACK && !drv.uart_busy && !timeout_hit) begin
                timer_q <= timer_q + 1'b1;
            end
            if (timeout_hit) tx_timeout <= 1'b1;
        end
    end

    assign drv.uart_start = uart_start_q;
    assign drv.uart_data  = uart_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder

module tb_uart_tx_feeder;
    localparam int WIDTH = 9;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;
    logic       tx_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_feeder_wr_if  #(.WIDTH(WIDTH)) wr_bus ();
    uart_tx_feeder_drv_if #(.WIDTH(WIDTH)) drv_bus ();

    uart_tx_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BUSY_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (wr_bus.slave),
        .flush      (flush),
        .drv        (drv_bus.master),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .tx_timeout (tx_timeout)
    );

    always #5 clk = ~clk;

    // Driver model: busy rises one cycle after start, stays up busy_len cycles.
    bit             ack_en      = 1'b1;
    bit             ready_en    = 1'b1;
    int             busy_len    = 200;
    int             busy_left   = 0;
    bit             ack_pending = 1'b0;
    int             start_cnt   = 0;
    logic [8:0]     start_log [$];

    always @(negedge clk) begin
        if (ack_pending)        busy_left = busy_len;
        else if (busy_left > 0) busy_left = busy_left - 1;
        ack_pending = (drv_bus.uart_start === 1'b1) && ack_en;
        if (drv_bus.uart_start === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_log.push_back(drv_bus.uart_data);
        end
        drv_bus.uart_busy  = (busy_left > 0);
        drv_bus.uart_ready = (busy_left == 0) && ready_en;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [8:0] d);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data  = d;
        tick();
        wr_bus.wr_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (drv_bus.uart_start === 1'b1) break;
            tick();
        end
        chk(tag, 32'(drv_bus.uart_start), 32'd1);
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_start"},   32'(drv_bus.uart_start), 32'd0);
        chk({pfx, "_data"},    32'(drv_bus.uart_data),  32'd0);
        chk({pfx, "_count"},   32'(fifo_count),         32'd0);
        chk({pfx, "_empty"},   32'(fifo_empty),         32'd1);
        chk({pfx, "_full"},    32'(fifo_full),          32'd0);
        chk({pfx, "_wrready"}, 32'(wr_bus.wr_ready),    32'd1);
        chk({pfx, "_ovf"},     32'(overflow),           32'd0);
        chk({pfx, "_tmo"},     32'(tx_timeout),         32'd0);
    endtask

    int s0;

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_data  = '0;
        repeat (3) tick();
        chk_reset_state("rst");
        rst_n = 1'b1;
        tick();

        // single word: exact launch latency and one pulse only
        wr(9'h155);
        chk("t1_count_after_wr", 32'(fifo_count), 32'd1);
        tick();
        chk("t1_start_n1", 32'(drv_bus.uart_start), 32'd0);
        tick();
        chk("t1_start_n2", 32'(drv_bus.uart_start), 32'd1);
        chk("t1_data",     32'(drv_bus.uart_data),  32'h155);
        chk("t1_empty",    32'(fifo_empty),         32'd1);
        tick();
        chk("t1_start_pulse", 32'(drv_bus.uart_start), 32'd0);
        repeat (210) tick();
        chk("t1_start_cnt", 32'(start_cnt),         32'd1);
        chk("t1_data_hold", 32'(drv_bus.uart_data), 32'h155);

        // fill with driver not ready, then overflow
        ready_en = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) wr(9'(i));
        chk("t2_full",    32'(fifo_full),       32'd1);
        chk("t2_count",   32'(fifo_count),      32'd16);
        chk("t2_wrready", 32'(wr_bus.wr_ready), 32'd0);
        chk("t2_ovf_pre", 32'(overflow),        32'd0);
        wr(9'h0AA);
        chk("t2_ovf",       32'(overflow),   32'd1);
        chk("t2_count_ovf", 32'(fifo_count), 32'd16);
        chk("t2_no_start",  32'(start_cnt),  32'd1);

        // drain in order
        busy_len = 4;
        ready_en = 1'b1;
        for (int i = 0; i < 600 && start_cnt < 17; i++) tick();
        chk("t3_start_cnt", 32'(start_cnt),  32'd17);
        chk("t3_count",     32'(fifo_count), 32'd0);
        for (int i = 0; i < 16; i++) chk($sformatf("t3_order%0d", i), 32'(start_log[i+1]), 32'(i));
        repeat (20) tick();
        chk("t3_no_extra", 32'(start_cnt),  32'd17);
        chk("t3_empty",    32'(fifo_empty), 32'd1);

        // driver never acknowledges
        ack_en = 1'b0;
        wr(9'h012);
        wr(9'h034);
        wait_start("t4_start1_seen");
        chk("t4_data1", 32'(drv_bus.uart_data), 32'h012);
        repeat (7) tick();
        chk("t4_tmo_t7", 32'(tx_timeout), 32'd0);
        tick();
        chk("t4_tmo_t8", 32'(tx_timeout), 32'd1);
        tick();
        chk("t4_start_t9", 32'(drv_bus.uart_start), 32'd0);
        tick();
        chk("t4_start_t10", 32'(drv_bus.uart_start), 32'd1);
        chk("t4_data2",     32'(drv_bus.uart_data),  32'h034);
        repeat (12) tick();
        chk("t4_tmo_sticky", 32'(tx_timeout), 32'd1);
        chk("t4_count",      32'(fifo_count), 32'd0);

        // flush during WAIT_DONE with a simultaneous write
        ack_en   = 1'b1;
        busy_len = 30;
        ready_en = 1'b0;
        tick();
        for (int i = 1; i <= 6; i++) wr(9'h100 + 9'(i));
        chk("t5_count6", 32'(fifo_count), 32'd6);
        ready_en = 1'b1;
        wait_start("t5_start_seen");
        chk("t5_data",   32'(drv_bus.uart_data), 32'h101);
        chk("t5_count5", 32'(fifo_count),        32'd5);
        repeat (3) tick();
        chk("t5_ovf_pre", 32'(overflow), 32'd1);
        s0 = start_cnt;
        flush           = 1'b1;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_data  = 9'h1FF;
        tick();
        flush           = 1'b0;
        wr_bus.wr_valid = 1'b0;
        chk("t5_count0",    32'(fifo_count),        32'd0);
        chk("t5_ovf_clr",   32'(overflow),          32'd0);
        chk("t5_empty",     32'(fifo_empty),        32'd1);
        chk("t5_data_hold", 32'(drv_bus.uart_data), 32'h101);
        repeat (60) tick();
        chk("t5_no_start", 32'(start_cnt),  32'(s0));
        chk("t5_count_end", 32'(fifo_count), 32'd0);

        // reset in WAIT_DONE with words queued
        ready_en = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) wr(9'h200 + 9'(i));
        ready_en = 1'b1;
        wait_start("t6_start_seen");
        chk("t6_count3", 32'(fifo_count), 32'd3);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk_reset_state("t6");
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
